// File: rtl/pixel_framebuffer_writer.sv
// pixel_framebuffer_writer: queues solver pixels and writes each as one byte over Avalon-MM.
// Define COLOR_LOG_MAP_EN to write a log-bucketed colour instead of the raw value.
module pixel_framebuffer_writer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480
) (
    input  logic                        output_clk,
    input  logic                        reset_n,
    input  logic [9:0]                  pixel_x,
    input  logic [8:0]                  pixel_y,
    input  logic [7:0]                  pixel_color,
    input  logic                        pixel_stb,
    output logic [31:0]                 avm_address,
    output logic                        avm_write,
    output logic [7:0]                  avm_writedata,
    input  logic                        avm_waitrequest,
    output logic                        frame_written_stb,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FRAME = H_RES * V_RES;
    localparam int CW = $clog2(FRAME);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_nxt;

    logic [26:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [26:0]   head;
    logic [7:0]    color, head_data;
    logic [31:0]   head_addr;
    logic          in_range, empty, full, push, pop, accept;

    assign head = mem[rd_ptr];
    assign color = head[7:0];
    assign empty = fifo_level == '0;
    assign full = fifo_level == FULL_LVL;
    assign in_range = 32'(pixel_x) < 32'(H_RES) && 32'(pixel_y) < 32'(V_RES);
    assign accept = state == WRITE && !avm_waitrequest;
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign pop = !empty && (state == IDLE || accept);
    assign push = pixel_stb && in_range && (!full || pop);
    assign head_addr = BASE_ADDR + 32'(head[16:8]) * 32'(H_RES) + 32'(head[26:17]);

`ifdef COLOR_LOG_MAP_EN
    assign head_data = color <= 8'd2 ? 8'd0 : color <= 8'd4 ? 8'd1 : color <= 8'd8 ? 8'd2 :
                       color <= 8'd16 ? 8'd4 : color <= 8'd32 ? 8'd8 : color <= 8'd64 ? 8'd16 :
                       color <= 8'd128 ? 8'd32 : 8'd64;
`else
    assign head_data = color;
`endif

    always_ff @(posedge output_clk) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE || accept) ? (empty ? IDLE : WRITE) : state;
    end

    always_comb begin
        avm_write = state == WRITE;
    end

    always_ff @(posedge output_clk) begin
        if (push) mem[wr_ptr] <= {pixel_x, pixel_y, pixel_color};
    end

    always_ff @(posedge output_clk) begin
        if (!reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_level        <= '0;
            count             <= '0;
            overflow          <= 1'b0;
            frame_written_stb <= 1'b0;
            avm_address       <= '0;
            avm_writedata     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr        <= rd_ptr + AW'(1);
                avm_address   <= head_addr;
                avm_writedata <= head_data;
            end
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (pixel_stb && in_range && full && !pop) overflow <= 1'b1;
            frame_written_stb <= accept && count == LAST;
            if (accept) count <= count == LAST ? '0 : count + CW'(1);
        end
    end
endmodule

// File: tb/tb_pixel_framebuffer_writer.sv
// tb_pixel_framebuffer_writer: directed bench; a second small-frame instance covers frame pulses.
module tb_pixel_framebuffer_writer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic [7:0] c = '0;
    logic stb = 1'b0;
    logic wr_wait = 1'b0;
    logic [31:0] avm_address;
    logic avm_write;
    logic [7:0] avm_writedata;
    logic frame_written_stb, overflow;
    logic [4:0] fifo_level;

    logic [9:0] s_x = '0;
    logic [8:0] s_y = '0;
    logic [7:0] s_c = '0;
    logic s_stb = 1'b0;
    logic s_wait = 1'b0;
    logic [31:0] s_address;
    logic s_write;
    logic [7:0] s_data;
    logic s_frame, s_overflow;
    logic [4:0] s_level;

    int vectors = 0;
    int miscompares = 0;
    logic [39:0] wlog[$];

    always #5 clk = ~clk;

    pixel_framebuffer_writer dut (
        .output_clk(clk), .reset_n(reset_n), .pixel_x(x), .pixel_y(y), .pixel_color(c),
        .pixel_stb(stb), .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(wr_wait),
        .frame_written_stb(frame_written_stb), .overflow(overflow), .fifo_level(fifo_level)
    );

    pixel_framebuffer_writer #(.H_RES(4), .V_RES(2)) dut_s (
        .output_clk(clk), .reset_n(reset_n), .pixel_x(s_x), .pixel_y(s_y), .pixel_color(s_c),
        .pixel_stb(s_stb), .avm_address(s_address), .avm_write(s_write),
        .avm_writedata(s_data), .avm_waitrequest(s_wait),
        .frame_written_stb(s_frame), .overflow(s_overflow), .fifo_level(s_level)
    );

    always @(negedge clk)
        if (reset_n && avm_write && !wr_wait) wlog.push_back({avm_address, avm_writedata});

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] expd(input logic [7:0] v);
`ifdef COLOR_LOG_MAP_EN
        return v <= 8'd2 ? 8'd0 : v <= 8'd4 ? 8'd1 : v <= 8'd8 ? 8'd2 : v <= 8'd16 ? 8'd4 :
               v <= 8'd32 ? 8'd8 : v <= 8'd64 ? 8'd16 : v <= 8'd128 ? 8'd32 : 8'd64;
`else
        return v;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
        vectors++;
        if ({avm_write, overflow, frame_written_stb} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 000", {avm_write, overflow, frame_written_stb});
        end
        vectors++;
        if (fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_level got %0d exp 0", fifo_level);
        end
        vectors++;
        if ({avm_address, avm_writedata} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_bus got %h exp 0", {avm_address, avm_writedata});
        end
    endtask

    task automatic test_single;
        wlog.delete();
        wr_wait = 1'b0;
        x = 10'd5; y = 9'd2; c = 8'h37; stb = 1'b1;
        tick;
        stb = 1'b0;
        vectors++;
        if ({avm_write, fifo_level} !== {1'b0, 5'd1}) begin
            miscompares++;
            $display("FAIL single_enq got write=%b level=%0d exp write=0 level=1", avm_write, fifo_level);
        end
        tick;
        vectors++;
        if ({avm_write, avm_address, avm_writedata} !== {1'b1, 32'd1285, expd(8'h37)}) begin
            miscompares++;
            $display("FAIL single_write got %b %0d %h exp 1 1285 %h", avm_write, avm_address, avm_writedata, expd(8'h37));
        end
        tick;
        vectors++;
        if (avm_write !== 1'b0 || wlog.size() != 1) begin
            miscompares++;
            $display("FAIL single_idle got write=%b writes=%0d exp 0 1", avm_write, wlog.size());
        end
    endtask

    task automatic test_stall;
        wlog.delete();
        wr_wait = 1'b1;
        x = 10'd639; y = 9'd479; c = 8'hC8; stb = 1'b1;
        tick;
        stb = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({avm_write, avm_address, avm_writedata} !== {1'b1, 32'd307199, expd(8'hC8)}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got %b %0d %h exp 1 307199 %h", i, avm_write, avm_address, avm_writedata, expd(8'hC8));
            end
            if (i < 4) tick;
        end
        wr_wait = 1'b0;
        tick;
        vectors++;
        if ({avm_write, fifo_level} !== {1'b0, 5'd0} || wlog.size() != 1) begin
            miscompares++;
            $display("FAIL stall_done got write=%b level=%0d writes=%0d exp 0 0 1", avm_write, fifo_level, wlog.size());
        end
        vectors++;
        if (wlog.size() == 1 && wlog[0] !== {32'd307199, expd(8'hC8)}) begin
            miscompares++;
            $display("FAIL stall_log got %h exp %h", wlog[0], {32'd307199, expd(8'hC8)});
        end
    endtask

    task automatic test_out_of_range;
        wlog.delete();
        x = 10'd640; y = 9'd0; c = 8'h11; stb = 1'b1;
        tick;
        x = 10'd0; y = 9'd480;
        tick;
        stb = 1'b0;
        vectors++;
        if (fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL oor_level got %0d exp 0", fifo_level);
        end
        tick;
        tick;
        vectors++;
        if ({avm_write, overflow} !== 2'b00 || wlog.size() != 0) begin
            miscompares++;
            $display("FAIL oor_write got write=%b ovf=%b writes=%0d exp 0 0 0", avm_write, overflow, wlog.size());
        end
    endtask

    task automatic test_burst;
        int n;
        logic [39:0] e;
        wlog.delete();
        wr_wait = 1'b1;
        x = 10'd1; y = 9'd3; c = 8'h05; stb = 1'b1;
        tick;
        stb = 1'b0;
        tick;
        vectors++;
        if (avm_write !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_lead got write=%b exp 1", avm_write);
        end
        for (int i = 0; i < 20; i++) begin
            x = 10'(i); y = 9'd10; c = 8'(i * 11 + 3); stb = 1'b1;
            tick;
            vectors++;
            if (fifo_level !== 5'(i < 16 ? i + 1 : 16) || overflow !== (i >= 16)) begin
                miscompares++;
                $display("FAIL burst_fill[%0d] got level=%0d ovf=%b exp %0d %b", i, fifo_level, overflow, i < 16 ? i + 1 : 16, i >= 16);
            end
        end
        stb = 1'b0;
        wr_wait = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            if (avm_write) n++;
            tick;
        end
        vectors++;
        if (n != 17 || fifo_level !== 5'd0 || overflow !== 1'b1 || wlog.size() != 17) begin
            miscompares++;
            $display("FAIL burst_drain got cycles=%0d level=%0d ovf=%b writes=%0d exp 17 0 1 17", n, fifo_level, overflow, wlog.size());
        end
        for (int j = 0; j < 17 && j < wlog.size(); j++) begin
            e = j == 0 ? {32'd1921, expd(8'h05)} : {32'(6400 + j - 1), expd(8'((j - 1) * 11 + 3))};
            vectors++;
            if (wlog[j] !== e) begin
                miscompares++;
                $display("FAIL burst_order[%0d] got %h exp %h", j, wlog[j], e);
            end
        end
    endtask

    task automatic test_reset_mid;
        wlog.delete();
        wr_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = 10'(100 + i); y = 9'd20; c = 8'(i); stb = 1'b1;
            tick;
        end
        stb = 1'b0;
        vectors++;
        if ({avm_write, fifo_level} !== {1'b1, 5'd3}) begin
            miscompares++;
            $display("FAIL rstmid_setup got write=%b level=%0d exp 1 3", avm_write, fifo_level);
        end
        reset_n = 1'b0;
        tick;
        vectors++;
        if ({avm_write, overflow, fifo_level} !== {1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL rstmid_abort got write=%b ovf=%b level=%0d exp 0 0 0", avm_write, overflow, fifo_level);
        end
        reset_n = 1'b1;
        wr_wait = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        vectors++;
        if (avm_write !== 1'b0 || wlog.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet got write=%b writes=%0d exp 0 0", avm_write, wlog.size());
        end
    endtask

    task automatic test_frame;
        int acc_n, pulses;
        logic acc;
        acc_n = 0;
        pulses = 0;
        s_wait = 1'b0;
        for (int cyc = 0; cyc < 26; cyc++) begin
            s_stb = cyc < 16;
            s_x = 10'(cyc % 4);
            s_y = 9'((cyc / 4) % 2);
            s_c = 8'(cyc);
            acc = s_write && !s_wait;
            if (acc) acc_n++;
            tick;
            vectors++;
            if (s_frame !== (acc && acc_n % 8 == 0)) begin
                miscompares++;
                $display("FAIL frame_pulse[%0d] got %b exp %b", cyc, s_frame, acc && acc_n % 8 == 0);
            end
            if (s_frame) pulses++;
        end
        s_stb = 1'b0;
        vectors++;
        if (pulses != 2 || acc_n != 16 || s_level !== 5'd0 || s_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_total got pulses=%0d writes=%0d level=%0d ovf=%b exp 2 16 0 0", pulses, acc_n, s_level, s_overflow);
        end
        vectors++;
        if ({s_address, s_data} !== {32'd7, expd(8'd15)}) begin
            miscompares++;
            $display("FAIL frame_last got %h exp %h", {s_address, s_data}, {32'd7, expd(8'd15)});
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_stall;
        test_out_of_range;
        test_burst;
        test_reset_mid;
        test_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
